// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter.
package mem_arb_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BURST_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t BUSY_I = 2'd1;
    localparam state_t BUSY_D = 2'd2;
    localparam state_t RESP   = 2'd3;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter, bundled in one interface.
interface mem_arbiter_if
    import mem_arb_pkg::*;
    ();

    logic              if_req;
    logic [WORD_W-1:0] if_addr;
    logic [WORD_W-1:0] if_rdata;
    logic              if_ready;
    logic              stall_if;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [WORD_W-1:0] d_rdata;
    logic              d_ready;
    logic              stall_mem;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, stall_if, d_rdata, d_ready, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    // Pipeline + memory view
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, stall_if, d_rdata, d_ready, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Serializes IF and MEM stage accesses onto one variable-latency memory.
// MEM has priority; a burst counter forces a fetch grant after MAX_D_BURST data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic          clk,
    input  logic          reset_b,
    mem_arbiter_if.slave  bus
);

    state_t              r_state;
    logic [BURST_W-1:0]  r_burst_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [WORD_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic [WORD_W-1:0]   r_if_rdata;
    logic [WORD_W-1:0]   r_d_rdata;
    logic                r_if_ready;
    logic                r_d_ready;

    logic                w_burst_max;
    logic                w_any_req;
    logic                w_sel;

    assign w_burst_max = (r_burst_cnt == BURST_W'(MAX_D_BURST));
    assign w_any_req   = bus.if_req | bus.d_req;
    // Data wins unless a fetch has waited through a full data burst
    assign w_sel       = (bus.d_req && !(bus.if_req && w_burst_max)) ? SEL_D : SEL_I;

    always_ff @(posedge clk) begin
        if (reset_b) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_mem_req <= 1'b1;
                        if (w_sel == SEL_D) begin
                            r_state     <= BUSY_D;
                            r_mem_we    <= bus.d_we;
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                            if (!bus.if_req) begin
                                r_burst_cnt <= '0;
                            end else if (!w_burst_max) begin
                                r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                            end
                        end else begin
                            r_state     <= BUSY_I;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= bus.if_addr;
                            r_mem_wdata <= '0;
                            r_burst_cnt <= '0;
                        end
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ack) begin
                        r_state    <= RESP;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_if_rdata <= bus.mem_rdata;
                        r_if_ready <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_d_rdata <= r_mem_we ? '0 : bus.mem_rdata;
                        r_d_ready <= 1'b1;
                    end
                end
                RESP: begin
                    r_state    <= IDLE;
                    r_if_ready <= 1'b0;
                    r_d_ready  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.d_ready   = r_d_ready;
    assign bus.stall_if  = bus.if_req & ~r_if_ready;
    assign bus.stall_mem = bus.d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a configurable-latency memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_b;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_D_BURST(4)) u_dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: acks in the lat-th cycle of mem_req
    int          lat       = 1;
    logic        ack_en    = 1'b1;
    logic        force_ack = 1'b0;
    logic [31:0] mem_data  = 32'h0;
    int          lat_cnt   = 0;

    always @(posedge clk) begin
        if (reset_b || !bus.mem_req || bus.mem_ack) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
    end

    assign bus.mem_ack   = force_ack | (ack_en & bus.mem_req & (lat_cnt == lat - 1));
    assign bus.mem_rdata = mem_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          req_cycles;
        int          pulses;
        logic        first;
        logic        prev;
        int          ng;
        int          gseq[6];
        int          exp_seq[6];
        int          rdy_cnt;
        int          req_seen;

        exp_seq = '{0, 0, 0, 0, 1, 0};
        reset_b     = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset values
        wait_cycles(2);
        check_val("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        check_val("rst_mem_addr", bus.mem_addr, 32'h0);
        check_val("rst_if_ready", {30'b0, bus.if_ready, bus.d_ready}, 32'h0);
        check_val("rst_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
        reset_b = 1'b0;
        wait_cycles(1);

        // Lone fetch, 1-cycle memory
        lat         = 1;
        mem_data    = 32'h2008_0005;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        #1;
        check_val("f_stall_c0", {31'b0, bus.stall_if}, 32'h1);
        @(negedge clk);
        check_val("f_mem_req", {31'b0, bus.mem_req}, 32'h1);
        check_val("f_mem_addr", bus.mem_addr, 32'h40);
        check_val("f_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check_val("f_stall_c1", {31'b0, bus.stall_if}, 32'h1);
        @(negedge clk);
        check_val("f_ready", {31'b0, bus.if_ready}, 32'h1);
        check_val("f_rdata", bus.if_rdata, 32'h2008_0005);
        check_val("f_stall_c2", {31'b0, bus.stall_if}, 32'h0);
        bus.if_req = 1'b0;
        @(negedge clk);
        check_val("f_ready_drop", {31'b0, bus.if_ready}, 32'h0);
        check_val("f_rdata_hold", bus.if_rdata, 32'h2008_0005);

        // Store, 3-cycle memory; memory drives nonzero read data to expose capture
        wait_cycles(1);
        lat         = 3;
        mem_data    = 32'h5A5A_5A5A;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h100;
        bus.d_wdata = 32'hDEAD_BEEF;
        req_cycles  = 0;
        pulses      = 0;
        first       = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                req_cycles++;
                if (first) begin
                    first = 1'b0;
                    check_val("s_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
                    check_val("s_we", {31'b0, bus.mem_we}, 32'h1);
                    check_val("s_stall", {31'b0, bus.stall_mem}, 32'h1);
                end
            end
            if (bus.d_ready) begin
                pulses++;
                check_val("s_rdata", bus.d_rdata, 32'h0);
                bus.d_req = 1'b0;
                bus.d_we  = 1'b0;
            end
        end
        check_val("s_req_cycles", req_cycles, 32'd3);
        check_val("s_pulses", pulses, 32'd1);
        check_val("s_if_rdata_kept", bus.if_rdata, 32'h2008_0005);

        // Simultaneous requests: data first, fetch right after
        lat         = 1;
        mem_data    = 32'h1111_2222;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h80;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h200;
        @(negedge clk);
        check_val("sim_first_addr", bus.mem_addr, 32'h200);
        @(negedge clk);
        check_val("sim_d_ready", {31'b0, bus.d_ready}, 32'h1);
        check_val("sim_d_rdata", bus.d_rdata, 32'h1111_2222);
        check_val("sim_if_rdata_kept", bus.if_rdata, 32'h2008_0005);
        bus.d_req = 1'b0;
        mem_data  = 32'h3333_4444;
        @(negedge clk);
        check_val("sim_idle_gap", {31'b0, bus.mem_req}, 32'h0);
        @(negedge clk);
        check_val("sim_fetch_req", {31'b0, bus.mem_req}, 32'h1);
        check_val("sim_fetch_addr", bus.mem_addr, 32'h80);
        @(negedge clk);
        check_val("sim_if_ready", {31'b0, bus.if_ready}, 32'h1);
        check_val("sim_if_rdata", bus.if_rdata, 32'h3333_4444);
        check_val("sim_d_rdata_kept", bus.d_rdata, 32'h1111_2222);
        bus.if_req = 1'b0;
        wait_cycles(2);

        // Starvation bound: 4 data grants, 1 fetch, then data again
        for (int i = 0; i < 6; i++) gseq[i] = 2;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'hC0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h300;
        ng   = 0;
        prev = 1'b0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            if (bus.mem_req && !prev) begin
                gseq[ng] = (bus.mem_addr == 32'hC0) ? 1 : 0;
                ng++;
            end
            prev = bus.mem_req;
        end
        for (int i = 0; i < 6; i++) check_val($sformatf("burst_grant%0d", i), gseq[i], exp_seq[i]);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        wait_cycles(4);

        // Reset during BUSY_D with the ack withheld
        ack_en      = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h400;
        bus.d_wdata = 32'hAAAA_5555;
        @(negedge clk);
        check_val("r_busy_req", {31'b0, bus.mem_req}, 32'h1);
        check_val("r_busy_wdata", bus.mem_wdata, 32'hAAAA_5555);
        reset_b   = 1'b1;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        @(negedge clk);
        check_val("r_mem_req", {31'b0, bus.mem_req}, 32'h0);
        check_val("r_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check_val("r_mem_addr", bus.mem_addr, 32'h0);
        check_val("r_mem_wdata", bus.mem_wdata, 32'h0);
        check_val("r_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
        check_val("r_ready", {30'b0, bus.if_ready, bus.d_ready}, 32'h0);
        reset_b   = 1'b0;
        force_ack = 1'b1;
        rdy_cnt   = 0;
        req_seen  = 0;
        @(negedge clk);
        force_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.if_ready || bus.d_ready) rdy_cnt++;
            if (bus.mem_req) req_seen++;
        end
        check_val("r_late_ack_ready", rdy_cnt, 32'd0);
        check_val("r_late_ack_req", req_seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store). The arbiter serializes accesses, drives the memory-side request/acknowledge handshake, and returns per-port ready pulses and stall levels to the pipeline. The MEM stage has priority, and a bounded-burst counter guarantees fetch progress. It sits between the pipeline stages and the unified memory.

## Interface
- MAX_D_BURST, 4, max consecutive data grants while a fetch is pending (1..15)
- clk  input  1  clock, all state updates on rising edge
- reset_b  input  1  synchronous, active-high reset (1 = reset)
- if_req  input  1  fetch request; held with if_addr until if_ready
- if_addr  input  32  fetch byte address
- if_rdata  output  32  fetched word; valid in if_ready cycle, held after
- if_ready  output  1  one-cycle completion pulse for fetch
- stall_if  output  1  if_req & ~if_ready
- d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_ready
- d_we  input  1  1 = store, 0 = load
- d_addr  input  32  data byte address
- d_wdata  input  32  store data
- d_rdata  output  32  load data; valid in d_ready cycle, held after
- d_ready  output  1  one-cycle completion pulse for data
- stall_mem  output  1  d_req & ~d_ready
- mem_req  output  1  memory request; held until mem_ack sampled
- mem_we  output  1  memory write enable
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data; valid with mem_ack
- mem_ack  input  1  memory completion, one cycle, may come in first mem_req cycle

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: if neither request is present, stay in IDLE. Otherwise pick a grant, latch address, we and wdata into registers, and go to BUSY_I or BUSY_D.
- Grant rule: data wins if d_req is set, unless if_req is set and burst_cnt == MAX_D_BURST; in that case fetch wins.
- burst_cnt: increments on a data grant while if_req is high. Clears on any fetch grant, and on a data grant with if_req low. Saturates at MAX_D_BURST.
- BUSY_x: mem_req=1 and mem_* are driven from the latched registers.
  - When mem_ack=1, capture mem_rdata into the granted port's rdata register. For a store, capture 0 instead.
  - Then go to RESP.
- RESP: pulse x_ready for exactly one cycle, then go to IDLE. The requester may drop or change its req at the following edge.
- Requests are never evaluated in RESP. A req still high when the FSM is back in IDLE is a new request.
- mem_ack while in IDLE or RESP is ignored.
- The other port's rdata is never modified.

## Timing
- Reset values: state IDLE, burst_cnt 0, mem_req/mem_we 0, mem_addr/mem_wdata 0, if_rdata/d_rdata 0, if_ready/d_ready 0.
- All mem_* outputs, rdata and ready come from registers. Only stall_if and stall_mem are combinational.
- Minimum latency: req seen at edge 0, mem_req high in cycle 1, ack in cycle 1, ready in cycle 2. Total is 3 cycles from req to ready for a one-cycle memory.
- Throughput: one access per (memory latency + 2) cycles.
- Reset mid-access: mem_req drops at the reset edge and the access is abandoned. The memory must tolerate the abort.
- Address and data are latched at grant time. Requester changes during BUSY do not affect mem_*.

## Structure
- Shared package mem_arb_pkg holds:
  - state typedef (IDLE, BUSY_I, BUSY_D, RESP)
  - port-select constants (SEL_I, SEL_D)
  - word width constant 32
- Single module; no sub-module is needed. The grant decision is a few lines of combinational logic feeding the IDLE transition.

## Test plan
- Lone fetch, 1-cycle memory: if_req=1, if_addr=0x0000_0040, memory returns 0x2008_0005.
  - mem_req in cycle 1 with mem_addr=0x40, mem_we=0.
  - if_ready in cycle 2 with if_rdata=0x2008_0005; stall_if high in cycles 0-1.
- Store, 3-cycle memory: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF.
  - mem_req held 3 cycles with mem_wdata=0xDEAD_BEEF.
  - d_ready pulses once; d_rdata=0.
- Simultaneous requests: if_req and d_req both high in IDLE.
  - Data is granted first; fetch is granted immediately after the data RESP.
  - if_rdata is unchanged during the data access.
- Starvation bound with MAX_D_BURST=4: d_req is re-asserted after every ready while if_req stays high.
  - Exactly 4 data grants, then 1 fetch grant, then data resumes.
- Reset during BUSY_D: assert reset_b with mem_ack pending.
  - At the next edge mem_req=0, state is IDLE and all outputs are 0.
  - A late mem_ack produces no ready pulse.
